text_terminal_writer: RTL and testbench
=======================================

// Module: text_terminal_writer
// PURPOSE
//  Write-side companion of the text pixel generator: turns a byte stream (e.g. from an
//  SPI peripheral) into writes on the text RAM write port, as a simple terminal.
//  Keeps a cursor and handles CR/LF/BS/FF. Clears the screen after reset and on request.
//  The text RAM port is driven in the clk domain, so wire clk to the RAM's clk_text_wr.
// PARAMETERS
//  TEXT_WIDTH   60                         characters per text row
//  TEXT_HEIGHT  20                         text rows
//  TEXT_LEN     TEXT_WIDTH*TEXT_HEIGHT     text RAM depth
//  TEXT_SZ      $clog2(TEXT_LEN)           text RAM address width
//  FILL_CHAR    8'h20                      glyph written by clear and backspace
// PORTS
//  clk           in   1        sole clock; also drives text RAM wrclock
//  reset_n       in   1        synchronous, active-low reset
//  in_valid      in   1        in_char is valid
//  in_char       in   8        byte to display or control code
//  in_ready      out  1        byte accepted on this cycle when in_valid && in_ready
//  clear_req     in   1        1-cycle pulse: clear screen, home cursor
//  busy          out  1        a clear sweep is in progress
//  cursor_col    out  $clog2(TEXT_WIDTH)   current cursor column
//  cursor_row    out  $clog2(TEXT_HEIGHT)  current cursor row
//  text_wr_ena   out  1        text RAM write enable
//  text_wr_data  out  8        text RAM write data
//  text_wr_addr  out  TEXT_SZ  text RAM write address
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): go to CLEAR with clr_addr=0, cursor=(0,0), wr_ena=0.
//    in_ready=0, busy=1, and wr_data/addr=0 during reset. Reset mid-operation aborts.
//  - States: CLEAR, READY.
//  - CLEAR: one write per cycle, FILL_CHAR to clr_addr, for clr_addr = 0..TEXT_LEN-1.
//    On the cycle that writes TEXT_LEN-1, go to READY. busy=1 and in_ready=0 throughout.
//    The sweep takes TEXT_LEN cycles.
//  - READY: in_ready = !clear_req (combinational), busy=0.
//  - clear_req in either state: restart CLEAR at addr 0 and home the cursor.
//    If clear_req and in_valid are high on the same cycle, clear wins; the byte is not taken.
//  - Accepted byte, decoded on the accept cycle. Write outputs are registered: latency 1.
//    * 0x0D CR: col=0. No write.
//    * 0x0A LF: col=0, row+1. No write.
//    * 0x08 BS: if col>0, col-1 and write FILL_CHAR at the new position.
//      At col 0 there is no write and no move (no reverse line wrap).
//    * 0x0C FF: same as clear_req.
//    * Any other byte, including 0x00 and 0xFF (these are glyphs): write in_char at the
//      cursor address, then advance col. If col==TEXT_WIDTH-1, go to col 0 and row+1.
//  - Row advance from TEXT_HEIGHT-1 wraps to row 0. There is no scroll and no RAM read.
//  - Cursor address = row*TEXT_WIDTH + col. Keep it incrementally:
//    cur_addr, plus row_start (+TEXT_WIDTH per row, wraps to 0). No multiplier.
//  - text_wr_ena is high for exactly one cycle per write. It is 0 for CR, LF, and BS at col 0.
//  - One byte per cycle sustained. in_ready does not depend on in_valid.
//  - cursor_* are the registered cursor after any accepted byte's update.
// TESTING
//  - Reset then idle: exactly 1200 writes of 8'h20 at addr 0..1199 in order.
//    busy falls and in_ready rises on the next cycle.
//  - READY, bytes "AB": writes (0,'A') then (1,'B') on consecutive cycles; cursor=(2,0).
//  - 60 'x' then 'y': 'y' written at addr 60, cursor=(1,1).
//    Cursor at (59,19) + 'z': write addr 1199, cursor=(0,0).
//  - "AB",0x08: BS writes 8'h20 at addr 1, cursor=(1,0).
//    CR then BS: no write, cursor=(0,0). LF from (5,3): cursor=(0,4), no write.
//  - clear_req pulsed mid-sweep at addr 500: next write is addr 0 and 1200 writes follow.
//    clear_req with in_valid in READY: in_ready=0, byte not written, sweep starts.
//  - Random byte stream with random in_valid gaps vs. a reference terminal model:
//    RAM image matches, and text_wr_ena count equals printables plus BS-with-move.

Source files
------------

// File: rtl/text_terminal_writer.sv
// Byte-stream terminal front end for the text RAM write port: keeps a cursor,
// interprets CR/LF/BS/FF and sweeps the screen with FILL_CHAR after reset or on request.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | writing FILL_CHAR to every RAM cell, one per cycle; no input
// ST_READY | accepting bytes, one per cycle, into the cursor position
module text_terminal_writer #(
  parameter int         TEXT_WIDTH  = 60,
  parameter int         TEXT_HEIGHT = 20,
  parameter int         TEXT_LEN    = TEXT_WIDTH * TEXT_HEIGHT,
  parameter int         TEXT_SZ     = $clog2(TEXT_LEN),
  parameter logic [7:0] FILL_CHAR   = 8'h20
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_valid,
  input  logic [7:0]                     in_char,
  output logic                           in_ready,
  input  logic                           clear_req,
  output logic                           busy,
  output logic [$clog2(TEXT_WIDTH)-1:0]  cursor_col,
  output logic [$clog2(TEXT_HEIGHT)-1:0] cursor_row,
  output logic                           text_wr_ena,
  output logic [7:0]                     text_wr_data,
  output logic [TEXT_SZ-1:0]             text_wr_addr
);

  localparam int COL_W = $clog2(TEXT_WIDTH);
  localparam int ROW_W = $clog2(TEXT_HEIGHT);

  localparam logic [COL_W-1:0]   LAST_COL  = COL_W'(TEXT_WIDTH - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW  = ROW_W'(TEXT_HEIGHT - 1);
  localparam logic [TEXT_SZ-1:0] LAST_ADDR = TEXT_SZ'(TEXT_LEN - 1);
  localparam logic [TEXT_SZ-1:0] ROW_STEP  = TEXT_SZ'(TEXT_WIDTH);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t             state_q, state_d;
  logic [TEXT_SZ-1:0] clr_addr_q, clr_addr_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [TEXT_SZ-1:0] row_start_q, row_start_d;
  logic [TEXT_SZ-1:0] cur_addr_q, cur_addr_d;
  logic               wr_ena_q, wr_ena_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic [TEXT_SZ-1:0] wr_addr_q, wr_addr_d;

  logic               accept;
  logic               do_clear;
  logic [ROW_W-1:0]   row_adv;
  logic [TEXT_SZ-1:0] row_start_adv;

  assign in_ready     = reset_n && (state_q == ST_READY) && !clear_req;
  assign busy         = !reset_n || (state_q == ST_CLEAR);
  assign accept       = in_valid && in_ready;
  assign cursor_col   = col_q;
  assign cursor_row   = row_q;
  assign text_wr_ena  = wr_ena_q;
  assign text_wr_data = wr_data_q;
  assign text_wr_addr = wr_addr_q;

  // Row advance wraps to the top; the cursor address follows row_start, no multiply.
  assign row_adv       = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
  assign row_start_adv = (row_q == LAST_ROW) ? '0 : row_start_q + ROW_STEP;

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    col_d       = col_q;
    row_d       = row_q;
    row_start_d = row_start_q;
    cur_addr_d  = cur_addr_q;
    wr_ena_d    = 1'b0;
    wr_data_d   = wr_data_q;
    wr_addr_d   = wr_addr_q;
    do_clear    = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        if (clear_req) begin
          do_clear = 1'b1;
        end else begin
          wr_ena_d  = 1'b1;
          wr_data_d = FILL_CHAR;
          wr_addr_d = clr_addr_q;
          if (clr_addr_q == LAST_ADDR) state_d = ST_READY;
          else                         clr_addr_d = clr_addr_q + TEXT_SZ'(1);
        end
      end
      default: begin
        if (clear_req) begin
          do_clear = 1'b1;
        end else if (accept) begin
          case (in_char)
            CH_CR: begin
              col_d      = '0;
              cur_addr_d = row_start_q;
            end
            CH_LF: begin
              col_d       = '0;
              row_d       = row_adv;
              row_start_d = row_start_adv;
              cur_addr_d  = row_start_adv;
            end
            CH_BS: begin
              // No reverse wrap: backspace at column 0 is ignored entirely.
              if (col_q != '0) begin
                col_d      = col_q - COL_W'(1);
                cur_addr_d = cur_addr_q - TEXT_SZ'(1);
                wr_ena_d   = 1'b1;
                wr_data_d  = FILL_CHAR;
                wr_addr_d  = cur_addr_q - TEXT_SZ'(1);
              end
            end
            CH_FF: do_clear = 1'b1;
            default: begin
              wr_ena_d  = 1'b1;
              wr_data_d = in_char;
              wr_addr_d = cur_addr_q;
              if (col_q == LAST_COL) begin
                col_d       = '0;
                row_d       = row_adv;
                row_start_d = row_start_adv;
                cur_addr_d  = row_start_adv;
              end else begin
                col_d      = col_q + COL_W'(1);
                cur_addr_d = cur_addr_q + TEXT_SZ'(1);
              end
            end
          endcase
        end
      end
    endcase

    if (do_clear) begin
      state_d     = ST_CLEAR;
      clr_addr_d  = '0;
      col_d       = '0;
      row_d       = '0;
      row_start_d = '0;
      cur_addr_d  = '0;
      wr_ena_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_CLEAR;
      clr_addr_q  <= '0;
      col_q       <= '0;
      row_q       <= '0;
      row_start_q <= '0;
      cur_addr_q  <= '0;
      wr_ena_q    <= 1'b0;
      wr_data_q   <= '0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      col_q       <= col_d;
      row_q       <= row_d;
      row_start_q <= row_start_d;
      cur_addr_q  <= cur_addr_d;
      wr_ena_q    <= wr_ena_d;
      wr_data_q   <= wr_data_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

endmodule

// File: tb/tb_text_terminal_writer.sv
// Bench for text_terminal_writer: vector table, hand-written corner sequences and a
// random byte stream compared against a row/column terminal model.
module tb_text_terminal_writer;

  localparam int W   = 60;
  localparam int H   = 20;
  localparam int LEN = W * H;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_ready;
  logic        clear_req;
  logic        busy;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        text_wr_ena;
  logic [7:0]  text_wr_data;
  logic [10:0] text_wr_addr;

  text_terminal_writer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_char      (in_char),
    .in_ready     (in_ready),
    .clear_req    (clear_req),
    .busy         (busy),
    .cursor_col   (cursor_col),
    .cursor_row   (cursor_row),
    .text_wr_ena  (text_wr_ena),
    .text_wr_data (text_wr_data),
    .text_wr_addr (text_wr_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Write monitor: every enabled cycle is one RAM write.
  logic [7:0] dut_ram [LEN];
  int         wr_cnt = 0;
  int         wq_addr[$];
  int         wq_data[$];

  always @(negedge clk) begin
    if (text_wr_ena) begin
      dut_ram[text_wr_addr] = text_wr_data;
      wr_cnt = wr_cnt + 1;
      wq_addr.push_back(int'(text_wr_addr));
      wq_data.push_back(int'(text_wr_data));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] c);
    in_valid = 1'b1;
    in_char  = c;
    step();
    in_valid = 1'b0;
  endtask

  // Waits for busy to fall and verifies the logged sweep: LEN fill writes in address order.
  task automatic wait_sweep(input string name);
    int n;
    int bad;
    n = 0;
    while (busy && n < 1400) begin
      step();
      n++;
    end
    chk({name, " busy_fall"}, int'(busy), 0);
    chk({name, " in_ready_rise"}, int'(in_ready), 1);
    chk({name, " last_addr"}, int'(text_wr_addr), LEN - 1);
    chk({name, " write_count"}, wq_addr.size(), LEN);
    bad = 0;
    for (int i = 0; i < wq_addr.size(); i++)
      if (wq_addr[i] != i || wq_data[i] != 32'h20) bad++;
    chk({name, " order_fill"}, bad, 0);
  endtask

  typedef struct {
    logic       vld;
    logic [7:0] ch;
    logic       ready;
    logic       wen;
    int         addr;
    int         data;
    int         col;
    int         row;
  } vec_t;

  vec_t vecs[13];

  logic [7:0] ref_ram [LEN];
  int mcol, mrow, exp_w, w0, cur_bad, ram_bad, rdy_bad, n;
  logic       vld;
  logic [7:0] ch;

  initial begin
    vecs[0]  = '{1'b1, 8'h41, 1'b1, 1'b1, 0,  8'h41, 1, 0};
    vecs[1]  = '{1'b1, 8'h42, 1'b1, 1'b1, 1,  8'h42, 2, 0};
    vecs[2]  = '{1'b1, 8'h08, 1'b1, 1'b1, 1,  8'h20, 1, 0};
    vecs[3]  = '{1'b1, 8'h0D, 1'b1, 1'b0, 0,  0,     0, 0};
    vecs[4]  = '{1'b1, 8'h08, 1'b1, 1'b0, 0,  0,     0, 0};
    vecs[5]  = '{1'b0, 8'h51, 1'b1, 1'b0, 0,  0,     0, 0};
    vecs[6]  = '{1'b1, 8'h00, 1'b1, 1'b1, 0,  8'h00, 1, 0};
    vecs[7]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 1,  8'hFF, 2, 0};
    vecs[8]  = '{1'b1, 8'h0A, 1'b1, 1'b0, 0,  0,     0, 1};
    vecs[9]  = '{1'b1, 8'h43, 1'b1, 1'b1, 60, 8'h43, 1, 1};
    vecs[10] = '{1'b1, 8'h0D, 1'b1, 1'b0, 0,  0,     0, 1};
    vecs[11] = '{1'b1, 8'h08, 1'b1, 1'b0, 0,  0,     0, 1};
    vecs[12] = '{1'b1, 8'h44, 1'b1, 1'b1, 60, 8'h44, 1, 1};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    clear_req = 1'b0;
    repeat (3) step();
    chk("reset busy", int'(busy), 1);
    chk("reset in_ready", int'(in_ready), 0);
    chk("reset wr_ena", int'(text_wr_ena), 0);
    chk("reset wr_addr", int'(text_wr_addr), 0);
    chk("reset wr_data", int'(text_wr_data), 0);
    chk("reset col", int'(cursor_col), 0);
    chk("reset row", int'(cursor_row), 0);

    clear_log();
    reset_n = 1'b1;
    wait_sweep("reset_sweep");
    step();
    chk("post_sweep wr_ena", int'(text_wr_ena), 0);

    // Table-driven single-byte vectors from the home position.
    foreach (vecs[i]) begin
      in_valid = vecs[i].vld;
      in_char  = vecs[i].ch;
      #1;
      chk($sformatf("vec%0d in_ready", i), int'(in_ready), int'(vecs[i].ready));
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d wr_ena", i), int'(text_wr_ena), int'(vecs[i].wen));
      if (vecs[i].wen) begin
        chk($sformatf("vec%0d wr_addr", i), int'(text_wr_addr), vecs[i].addr);
        chk($sformatf("vec%0d wr_data", i), int'(text_wr_data), vecs[i].data);
      end
      chk($sformatf("vec%0d col", i), int'(cursor_col), vecs[i].col);
      chk($sformatf("vec%0d row", i), int'(cursor_row), vecs[i].row);
    end

    // clear_req together with a valid byte: clear wins, byte dropped.
    clear_log();
    in_valid  = 1'b1;
    in_char   = 8'h5A;
    clear_req = 1'b1;
    #1;
    chk("clr+valid in_ready", int'(in_ready), 0);
    step();
    in_valid  = 1'b0;
    clear_req = 1'b0;
    chk("clr+valid busy", int'(busy), 1);
    chk("clr+valid wr_ena", int'(text_wr_ena), 0);
    chk("clr+valid col", int'(cursor_col), 0);
    chk("clr+valid row", int'(cursor_row), 0);

    // Restart the sweep once it reaches address 500.
    n = 0;
    while (!(text_wr_ena && text_wr_addr == 11'd500) && n < 1400) begin
      step();
      n++;
    end
    chk("mid_sweep reach500", int'(text_wr_addr), 500);
    chk("mid_sweep partial_count", wq_addr.size(), 501);
    ram_bad = 0;
    for (int i = 0; i < wq_addr.size(); i++)
      if (wq_addr[i] != i || wq_data[i] != 32'h20) ram_bad++;
    chk("mid_sweep partial_fill_no_Z", ram_bad, 0);
    clear_log();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    chk("mid_sweep restart wr_ena", int'(text_wr_ena), 0);
    wait_sweep("mid_sweep");

    // Line wrap from the last column.
    repeat (60) send_byte(8'h78);
    send_byte(8'h79);
    chk("wrap y wr_ena", int'(text_wr_ena), 1);
    chk("wrap y addr", int'(text_wr_addr), 60);
    chk("wrap y data", int'(text_wr_data), 8'h79);
    chk("wrap y col", int'(cursor_col), 1);
    chk("wrap y row", int'(cursor_row), 1);

    // Bottom-right corner wraps to home.
    send_byte(8'h0D);
    repeat (18) send_byte(8'h0A);
    repeat (59) send_byte(8'h71);
    chk("corner pre col", int'(cursor_col), 59);
    chk("corner pre row", int'(cursor_row), 19);
    send_byte(8'h7A);
    chk("corner z wr_ena", int'(text_wr_ena), 1);
    chk("corner z addr", int'(text_wr_addr), 1199);
    chk("corner z data", int'(text_wr_data), 8'h7A);
    chk("corner z col", int'(cursor_col), 0);
    chk("corner z row", int'(cursor_row), 0);

    // LF from (5,3).
    repeat (3) send_byte(8'h0A);
    repeat (5) send_byte(8'h6B);
    chk("lf pre col", int'(cursor_col), 5);
    chk("lf pre row", int'(cursor_row), 3);
    send_byte(8'h0A);
    chk("lf wr_ena", int'(text_wr_ena), 0);
    chk("lf col", int'(cursor_col), 0);
    chk("lf row", int'(cursor_row), 4);

    // FF byte clears like clear_req.
    clear_log();
    send_byte(8'h0C);
    chk("ff busy", int'(busy), 1);
    chk("ff wr_ena", int'(text_wr_ena), 0);
    chk("ff col", int'(cursor_col), 0);
    chk("ff row", int'(cursor_row), 0);
    wait_sweep("ff_sweep");
    step();

    // Random stream against a row/column terminal model.
    for (int i = 0; i < LEN; i++) ref_ram[i] = 8'h20;
    mcol = 0; mrow = 0; exp_w = 0; cur_bad = 0; rdy_bad = 0;
    w0 = wr_cnt;
    for (int c = 0; c < 2000; c++) begin
      vld = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 9))
        0:       ch = 8'h0D;
        1:       ch = 8'h0A;
        2, 3:    ch = 8'h08;
        default: ch = 8'($urandom_range(0, 255));
      endcase
      if (ch == 8'h0C) ch = 8'h41;
      in_valid = vld;
      in_char  = ch;
      #1;
      if (!in_ready) rdy_bad++;
      step();
      if (vld) begin
        if (ch == 8'h0D) begin
          mcol = 0;
        end else if (ch == 8'h0A) begin
          mcol = 0;
          mrow = (mrow + 1) % H;
        end else if (ch == 8'h08) begin
          if (mcol > 0) begin
            mcol--;
            ref_ram[mrow * W + mcol] = 8'h20;
            exp_w++;
          end
        end else begin
          ref_ram[mrow * W + mcol] = ch;
          exp_w++;
          mcol++;
          if (mcol == W) begin
            mcol = 0;
            mrow = (mrow + 1) % H;
          end
        end
      end
      if (int'(cursor_col) != mcol || int'(cursor_row) != mrow) cur_bad++;
    end
    in_valid = 1'b0;
    step();
    ram_bad = 0;
    for (int i = 0; i < LEN; i++)
      if (dut_ram[i] !== ref_ram[i]) ram_bad++;
    chk("rand in_ready_low_cycles", rdy_bad, 0);
    chk("rand cursor_mismatch_cycles", cur_bad, 0);
    chk("rand write_count", wr_cnt - w0, exp_w);
    chk("rand ram_mismatch_cells", ram_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
